// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - instruction fetch stage: PC sequencing, redirect handling and one-entry skid buffer
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        stall_i,
    input  logic        pc_instr_invalid_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_ack_i,
    input  logic [31:0] inst_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        instr_valid_o
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        valid_q;
    logic [31:0] skid_pc_q;
    logic [31:0] skid_instr_q;
    logic [31:0] pend_q;
    logic        pend_flush_q;

    logic [31:0] redir_tgt_d;
    logic [31:0] seq_addr_d;
    logic        take_new_d;
    logic [31:0] drop_tgt_d;

    always_comb begin
        redir_tgt_d = flush_i ? new_pc_i : branch_target_i;
        seq_addr_d  = addr_q + 32'd4;
        // A pending flush target may only be replaced by a newer flush.
        take_new_d  = flush_i || (branch_flag_i && !pend_flush_q);
        drop_tgt_d  = take_new_d ? redir_tgt_d : pend_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= RESET_PC;
            pc_q         <= 32'd0;
            instr_q      <= 32'd0;
            valid_q      <= 1'b0;
            skid_pc_q    <= 32'd0;
            skid_instr_q <= 32'd0;
            pend_q       <= 32'd0;
            pend_flush_q <= 1'b0;
        end else begin
            if (pc_instr_invalid_i) valid_q <= 1'b0;
            if (flush_i) begin
                valid_q      <= 1'b0;
                skid_pc_q    <= 32'd0;
                skid_instr_q <= 32'd0;
            end
            case (state_q)
                IDLE: begin
                    state_q <= REQ;
                    addr_q  <= RESET_PC;
                end
                REQ: begin
                    if (inst_ack_i) begin
                        if (flush_i) begin
                            addr_q <= new_pc_i;
                        end else if (!stall_i) begin
                            // Branch with ack still delivers the delay-slot word.
                            pc_q    <= addr_q;
                            instr_q <= inst_rdata_i;
                            valid_q <= ~pc_instr_invalid_i;
                            addr_q  <= branch_flag_i ? branch_target_i : seq_addr_d;
                        end else if (branch_flag_i) begin
                            addr_q <= branch_target_i;
                        end else begin
                            skid_pc_q    <= addr_q;
                            skid_instr_q <= inst_rdata_i;
                            addr_q       <= seq_addr_d;
                            state_q      <= HOLD;
                        end
                    end else if (flush_i || branch_flag_i) begin
                        pend_q       <= redir_tgt_d;
                        pend_flush_q <= flush_i;
                        state_q      <= DROP;
                    end
                end
                HOLD: begin
                    if (flush_i || branch_flag_i) begin
                        addr_q       <= redir_tgt_d;
                        skid_pc_q    <= 32'd0;
                        skid_instr_q <= 32'd0;
                        state_q      <= REQ;
                    end else if (!stall_i) begin
                        pc_q    <= skid_pc_q;
                        instr_q <= skid_instr_q;
                        valid_q <= ~pc_instr_invalid_i;
                        state_q <= REQ;
                    end
                end
                DROP: begin
                    if (inst_ack_i) begin
                        addr_q       <= drop_tgt_d;
                        pend_q       <= 32'd0;
                        pend_flush_q <= 1'b0;
                        state_q      <= REQ;
                    end else if (take_new_d) begin
                        pend_q       <= redir_tgt_d;
                        pend_flush_q <= pend_flush_q | flush_i;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign inst_req_o    = (state_q == REQ) || (state_q == DROP);
    assign inst_addr_o   = addr_q;
    assign pc_o          = pc_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;

endmodule
